// File: rtl/fabric_cfg_pkg.sv
// fabric_cfg_pkg
// Shared constants, the loader state enum and the CRC-8 helper used by the
// fabric configuration loader.
//   SOF / EOS          : stream framing bytes
//   LT_CFG_W / SB_CFG_W: config word widths (logic tile / switch box)
//   LT_BYTES / SB_BYTES: payload bytes per frame type
//   CRC_POLY           : CRC-8 polynomial (x^8 + x^2 + x + 1)
package fabric_cfg_pkg;

  localparam logic [7:0] SOF      = 8'hA5;
  localparam logic [7:0] EOS      = 8'h5A;
  localparam int         LT_CFG_W = 33;
  localparam int         SB_CFG_W = 16;
  localparam int         LT_BYTES = 5;
  localparam int         SB_BYTES = 2;
  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DRAIN,
    ST_CRC,
    ST_COMMIT
  } state_t;

  // One byte of CRC-8 (init handled by caller, no reflection, no final xor).
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// cfg_crc8
// Running CRC-8 register over a byte stream.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (crc -> 0)
//   clear   : restart the CRC at 0 (wins over update)
//   update  : fold data into the running CRC this cycle
//   data    : byte to fold
//   crc     : current CRC value
module cfg_crc8
  import fabric_cfg_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       update,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (update) begin
      crc <= crc8_next(crc, data);
    end
  end

endmodule

// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader
// Byte-serial configuration loader: unpacks framed bytes (A5, header,
// LSB-first payload) into logic-tile (33-bit) or switch-box (16-bit) config
// words and pulses a one-hot write strobe for one cycle. Byte 5A in IDLE
// enables the fabric. Optional build macro FABRIC_CFG_CRC_EN adds a trailing
// CRC-8 byte per frame (over header + payload).
// Handshake: a byte moves on a rising edge where cfg_valid && cfg_ready;
// cfg_ready is low only in the single COMMIT cycle.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   cfg_valid/cfg_data      : incoming byte stream
//   cfg_ready               : loader accepts a byte this cycle
//   lt_cfg_we/lt_cfg_data   : logic-tile strobe (one-hot) and word
//   sb_cfg_we/sb_cfg_data   : switch-box strobe (one-hot) and word
//   fabric_en, cfg_err      : sticky status flags
//   frame_cnt               : committed frames, saturating at 255
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
#(
  parameter int N_LT = 4,
  parameter int N_SB = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cfg_valid,
  input  logic [7:0]          cfg_data,
  output logic                cfg_ready,
  output logic [N_LT-1:0]     lt_cfg_we,
  output logic [LT_CFG_W-1:0] lt_cfg_data,
  output logic [N_SB-1:0]     sb_cfg_we,
  output logic [SB_CFG_W-1:0] sb_cfg_data,
  output logic                fabric_en,
  output logic                cfg_err,
  output logic [7:0]          frame_cnt
);

`ifdef FABRIC_CFG_CRC_EN
  localparam int CRC_BYTES = 1;
`else
  localparam int CRC_BYTES = 0;
`endif

  // Byte-counter values of the final payload byte / final drained byte.
  localparam logic [2:0] LT_LAST       = 3'(LT_BYTES - 1);
  localparam logic [2:0] SB_LAST       = 3'(SB_BYTES - 1);
  localparam logic [2:0] LT_DRAIN_LAST = 3'(LT_BYTES + CRC_BYTES - 1);
  localparam logic [2:0] SB_DRAIN_LAST = 3'(SB_BYTES + CRC_BYTES - 1);

  state_t                state, state_nxt;
  logic                  is_sb_q;
  logic [6:0]            idx_q;
  logic [2:0]            cnt_q;
  logic [LT_CFG_W-1:0]   asm_q, asm_nxt, out_word;
  logic                  xfer, hdr_bad, last_byte, drain_done;
  logic                  load_out, set_err;

  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ready = (state != ST_COMMIT);

  assign hdr_bad    = cfg_data[7] ? ({1'b0, cfg_data[6:0]} >= 8'(N_SB))
                                  : ({1'b0, cfg_data[6:0]} >= 8'(N_LT));
  assign last_byte  = (cnt_q == (is_sb_q ? SB_LAST : LT_LAST));
  assign drain_done = (cnt_q == (is_sb_q ? SB_DRAIN_LAST : LT_DRAIN_LAST));

  // Place the incoming byte at its LSB-first position; only bit 0 of the
  // fifth logic-tile byte lands (FF select).
  always_comb begin
    asm_nxt = asm_q;
    case (cnt_q)
      3'd0:    asm_nxt[7:0]   = cfg_data;
      3'd1:    asm_nxt[15:8]  = cfg_data;
      3'd2:    asm_nxt[23:16] = cfg_data;
      3'd3:    asm_nxt[31:24] = cfg_data;
      default: asm_nxt[32]    = cfg_data[0];
    endcase
  end

`ifdef FABRIC_CFG_CRC_EN
  logic [7:0] crc_val;

  cfg_crc8 u_crc (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (state == ST_IDLE && xfer && cfg_data == SOF),
    .update (xfer && (state == ST_HDR || state == ST_PAYLOAD)),
    .data   (cfg_data),
    .crc    (crc_val)
  );

  // Word is complete in asm_q by the time the CRC byte arrives.
  assign out_word = asm_q;
`else
  // Output registers load in the same edge as the final payload byte.
  assign out_word = asm_nxt;
`endif

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer && cfg_data == SOF) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (xfer) begin
          if (hdr_bad) begin
            set_err   = 1'b1;
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (xfer && last_byte) begin
`ifdef FABRIC_CFG_CRC_EN
          state_nxt = ST_CRC;
`else
          load_out  = 1'b1;
          state_nxt = ST_COMMIT;
`endif
        end
      end
`ifdef FABRIC_CFG_CRC_EN
      ST_CRC: begin
        if (xfer) begin
          if (cfg_data == crc_val) begin
            load_out  = 1'b1;
            state_nxt = ST_COMMIT;
          end else begin
            set_err   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
`endif
      ST_DRAIN: begin
        if (xfer && drain_done) state_nxt = ST_IDLE;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      is_sb_q     <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      lt_cfg_data <= '0;
      sb_cfg_data <= '0;
      fabric_en   <= 1'b0;
      cfg_err     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_HDR && xfer) begin
        is_sb_q <= cfg_data[7];
        idx_q   <= cfg_data[6:0];
        cnt_q   <= '0;
        asm_q   <= '0;
      end
      if ((state == ST_PAYLOAD || state == ST_DRAIN) && xfer) begin
        cnt_q <= cnt_q + 3'd1;
        asm_q <= asm_nxt;
      end
      if (load_out) begin
        if (is_sb_q) sb_cfg_data <= out_word[SB_CFG_W-1:0];
        else         lt_cfg_data <= out_word;
      end
      if (set_err) cfg_err <= 1'b1;
      if (state == ST_IDLE && xfer && cfg_data == EOS) fabric_en <= 1'b1;
      if (state == ST_COMMIT && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    lt_cfg_we = '0;
    sb_cfg_we = '0;
    for (int i = 0; i < N_LT; i++)
      lt_cfg_we[i] = (state == ST_COMMIT) && !is_sb_q && (idx_q == 7'(i));
    for (int i = 0; i < N_SB; i++)
      sb_cfg_we[i] = (state == ST_COMMIT) && is_sb_q && (idx_q == 7'(i));
  end

endmodule
